// File: rtl/wam_round_scheduler.sv
// wam_round_scheduler: whack-a-mole round sequencer. Spawns pseudo-random moles, times the up
// window, judges keypad presses and keeps score, lives and the shrinking up window.
module wam_round_scheduler #(
  parameter int unsigned UP_TICKS       = 750,
  parameter int unsigned UP_MIN         = 250,
  parameter int unsigned UP_STEP        = 50,
  parameter int unsigned GAP_TICKS      = 200,
  parameter int unsigned HITS_PER_LEVEL = 8,
  parameter int unsigned LIVES          = 3,
  parameter logic [7:0]  SEED           = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       valid_key,
  input  logic [3:0] position,
  output logic [3:0] mole_pos,
  output logic       mole_up,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int unsigned MaxTicks = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int unsigned TW       = $clog2(MaxTicks + 1);
  localparam int unsigned LW       = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [TW-1:0] LUpTicks  = TW'(UP_TICKS);
  localparam logic [TW-1:0] LUpMin    = TW'(UP_MIN);
  localparam logic [TW-1:0] LUpStep   = TW'(UP_STEP);
  localparam logic [TW-1:0] LWinKnee  = TW'(UP_MIN + UP_STEP);
  localparam logic [TW-1:0] LGapLast  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] LOne      = TW'(1);
  localparam logic [LW-1:0] LLvlLast  = LW'(HITS_PER_LEVEL - 1);
  localparam logic [1:0]    LLives    = 2'(LIVES);

  typedef enum logic [2:0] {StIdle, StSpawn, StUp, StGap, StOver} state_e;

  state_e        r_state, w_state_nxt;
  logic [7:0]    r_lfsr;
  logic          r_key_prev, r_start_prev;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [TW-1:0] r_window, w_window_nxt;
  logic [LW-1:0] r_lvl_cnt, w_lvl_cnt_nxt;
  logic          r_first, w_first_nxt;
  logic [3:0]    r_mole_pos, w_mole_pos_nxt;
  logic [7:0]    r_score, w_score_nxt;
  logic [1:0]    r_lives, w_lives_nxt;
  logic          r_hit, w_hit_nxt;
  logic          r_miss, w_miss_nxt;
  logic          w_reinit;

  logic       w_key_evt, w_start_rise, w_lfsr_fb;
  logic [3:0] w_cand;

  assign w_key_evt    = valid_key & ~r_key_prev;
  assign w_start_rise = start & ~r_start_prev;
  assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cand       = r_lfsr[3:0];

  // Free-running LFSR and edge-detect history, updated every clk regardless of state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr       <= SEED;
      r_key_prev   <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
      r_key_prev   <= valid_key;
      r_start_prev <= start;
    end
  end

  // Game state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_timer    <= '0;
      r_window   <= LUpTicks;
      r_lvl_cnt  <= '0;
      r_first    <= 1'b1;
      r_mole_pos <= 4'd0;
      r_score    <= 8'd0;
      r_lives    <= LLives;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_window   <= w_window_nxt;
      r_lvl_cnt  <= w_lvl_cnt_nxt;
      r_first    <= w_first_nxt;
      r_mole_pos <= w_mole_pos_nxt;
      r_score    <= w_score_nxt;
      r_lives    <= w_lives_nxt;
      r_hit      <= w_hit_nxt;
      r_miss     <= w_miss_nxt;
    end
  end

  // Next-state: spawn, judge, gap timing and game restart
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_window_nxt   = r_window;
    w_lvl_cnt_nxt  = r_lvl_cnt;
    w_first_nxt    = r_first;
    w_mole_pos_nxt = r_mole_pos;
    w_score_nxt    = r_score;
    w_lives_nxt    = r_lives;
    w_hit_nxt      = 1'b0;
    w_miss_nxt     = 1'b0;
    w_reinit       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_reinit    = 1'b1;
          w_state_nxt = StSpawn;
        end
      end
      StSpawn: begin
        // The first mole of a game may land anywhere; later ones must move
        if ((w_cand <= 4'd8) && (r_first || (w_cand != r_mole_pos))) begin
          w_mole_pos_nxt = w_cand;
          w_timer_nxt    = '0;
          w_first_nxt    = 1'b0;
          w_state_nxt    = StUp;
        end
      end
      StUp: begin
        // A valid key wins over a timeout landing in the same clk
        if (w_key_evt && (position <= 4'd8)) begin
          w_timer_nxt = '0;
          w_state_nxt = StGap;
          if (position == r_mole_pos) begin
            w_hit_nxt = 1'b1;
            if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
            if (r_lvl_cnt == LLvlLast) begin
              w_lvl_cnt_nxt = '0;
              w_window_nxt  = (r_window >= LWinKnee) ? (r_window - LUpStep) : LUpMin;
            end else begin
              w_lvl_cnt_nxt = r_lvl_cnt + LW'(1);
            end
          end else begin
            w_miss_nxt  = 1'b1;
            w_lives_nxt = r_lives - 2'd1;
          end
        end else if (tick) begin
          if (r_timer == (r_window - LOne)) begin
            w_miss_nxt  = 1'b1;
            w_lives_nxt = r_lives - 2'd1;
            w_timer_nxt = '0;
            w_state_nxt = StGap;
          end else begin
            w_timer_nxt = r_timer + LOne;
          end
        end
      end
      StGap: begin
        if (r_lives == 2'd0) begin
          w_state_nxt = StOver;
        end else if (tick) begin
          if (r_timer == LGapLast) begin
            w_timer_nxt = '0;
            w_state_nxt = StSpawn;
          end else begin
            w_timer_nxt = r_timer + LOne;
          end
        end
      end
      StOver: begin
        if (w_start_rise) begin
          w_reinit    = 1'b1;
          w_state_nxt = StSpawn;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_reinit) begin
      w_score_nxt   = 8'd0;
      w_lives_nxt   = LLives;
      w_window_nxt  = LUpTicks;
      w_lvl_cnt_nxt = '0;
      w_first_nxt   = 1'b1;
      w_timer_nxt   = '0;
    end
  end

  assign mole_pos   = r_mole_pos;
  assign mole_up    = (r_state == StUp);
  assign score      = r_score;
  assign lives      = r_lives;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;
  assign game_over  = (r_state == StOver);

endmodule

// File: tb/tb_wam_round_scheduler.sv
// tb_wam_round_scheduler: randomized directed rounds against a score/lives/window model.
module tb_wam_round_scheduler;

  localparam int UpTicks  = 750;
  localparam int UpMin    = 250;
  localparam int UpStep   = 50;
  localparam int GapTicks = 200;
  localparam int Hpl      = 8;
  localparam int Lives    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       valid_key = 1'b0;
  logic [3:0] position = 4'd0;
  logic [3:0] mole_pos;
  logic       mole_up;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int         checks = 0;
  int         errors = 0;
  int         exp_score;
  int         exp_lives;
  int         hits;
  logic [3:0] prev_pos;
  bit         hold_key;

  wam_round_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .valid_key (valid_key),
    .position  (position),
    .mole_pos  (mole_pos),
    .mole_up   (mole_up),
    .score     (score),
    .lives     (lives),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Up window after h hits since game start: one step per Hpl hits, floored at UpMin
  function automatic int win(input int h);
    int w;
    w = UpTicks - UpStep * (h / Hpl);
    return (w < UpMin) ? UpMin : w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Apply inputs for one clk, then sample just after the edge
  task automatic step(input bit tk, input bit vk, input logic [3:0] pos);
    tick      = tk;
    valid_key = vk;
    position  = pos;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_up(input bit diff);
    bit ok;
    bit tk;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tk = 1'($urandom_range(0, 1));
      step(tk, hold_key, 4'd0);
      if (mole_up === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("spawn_up", 32'(ok), 1);
    chk("pos_range", 32'(mole_pos <= 4'd8), 1);
    if (diff) chk("pos_new", 32'(mole_pos != prev_pos), 1);
    prev_pos = mole_pos;
  endtask

  // kind: 0 timeout, 1 hit, 2 wrong key, 3 hit on the timeout tick
  task automatic round(input int kind, input int d, input bit pre9, input bit hold_next);
    logic [3:0] m, wrong, pos;
    int  w, t, g, i;
    bit  tk, vk, judge, is_hit, first;
    m     = mole_pos;
    w     = win(hits);
    wrong = 4'($urandom_range(0, 7));
    if (wrong >= m) wrong = wrong + 4'd1;
    if (pre9) begin
      step(1'b0, 1'b1, 4'd9);
      chk("pre9_up", 32'(mole_up), 1);
      chk("pre9_pulse", 32'({hit_pulse, miss_pulse}), 0);
      step(1'b0, 1'b0, 4'd9);
    end
    t = 0;
    i = 0;
    judge = 1'b0;
    while (!judge) begin
      tk  = (i % 2 == 0);
      i++;
      vk  = hold_key;
      pos = 4'd0;
      if (kind == 1 || kind == 2) begin
        if (t == d) begin
          judge = 1'b1;
          tk    = 1'b0;
          vk    = 1'b1;
          pos   = (kind == 1) ? m : wrong;
        end
      end else if (kind == 3) begin
        if (tk && t == w - 1) begin
          judge = 1'b1;
          vk    = 1'b1;
          pos   = m;
        end
      end else if (tk && t == w - 1) begin
        judge = 1'b1;
      end
      step(tk, vk, pos);
      if (tk) t++;
      if (!judge) begin
        chk("up_hold", 32'(mole_up), 1);
        chk("up_no_pulse", 32'({hit_pulse, miss_pulse}), 0);
      end
    end
    is_hit = (kind == 1 || kind == 3);
    if (is_hit) begin
      hits++;
      if (exp_score < 255) exp_score++;
    end else begin
      exp_lives--;
    end
    chk("judge_down", 32'(mole_up), 0);
    chk("hit_pulse", 32'(hit_pulse), 32'(is_hit));
    chk("miss_pulse", 32'(miss_pulse), 32'(!is_hit));
    chk("score", 32'(score), exp_score);
    chk("lives", 32'(lives), exp_lives);
    g = 0;
    first = 1'b1;
    while (1) begin
      tk = (i % 2 == 0);
      i++;
      vk = hold_next && (g >= 100);
      step(tk, vk, 4'd0);
      if (tk) g++;
      chk("gap_down", 32'(mole_up), 0);
      if (first) begin
        first = 1'b0;
        chk("pulse_1clk", 32'({hit_pulse, miss_pulse}), 0);
        chk("over_flag", 32'(game_over), 32'(exp_lives == 0));
        if (exp_lives == 0) break;
      end
      if (g == GapTicks) break;
    end
    hold_key = hold_next;
    if (exp_lives != 0) wait_up(1'b1);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tk, vk;
    int kind;
    hold_key  = 1'b0;
    exp_score = 0;
    exp_lives = Lives;
    hits      = 0;
    prev_pos  = 4'd0;

    repeat (3) step(1'b0, 1'b0, 4'd0);
    chk("rst_up", 32'(mole_up), 0);
    chk("rst_pos", 32'(mole_pos), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_lives", 32'(lives), Lives);
    chk("rst_pulses", 32'({hit_pulse, miss_pulse}), 0);
    chk("rst_over", 32'(game_over), 0);

    reset = 1'b1;
    start = 1'b1;
    wait_up(1'b0);

    round(0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 88; k++) begin
      kind = (k % 8 == 7) ? 3 : 1;
      round(kind, int'($urandom_range(0, 30)), ($urandom_range(0, 3) == 0), (k == 87));
    end
    // Key held high since the previous gap: only the timeout may judge this mole
    round(0, 0, 1'b0, 1'b0);
    round(2, int'($urandom_range(0, 30)), 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      tk = (k % 2 == 0);
      vk = (k % 3 == 0);
      step(tk, vk, 4'(k % 9));
      chk("over_hold", 32'(game_over), 1);
      chk("over_score", 32'(score), exp_score);
      chk("over_lives", 32'(lives), 0);
      chk("over_down", 32'(mole_up), 0);
    end
    start = 1'b0;
    step(1'b0, 1'b0, 4'd0);
    chk("over_start_low", 32'(game_over), 1);
    start = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    exp_score = 0;
    exp_lives = Lives;
    hits      = 0;
    chk("restart_over", 32'(game_over), 0);
    chk("restart_score", 32'(score), 0);
    chk("restart_lives", 32'(lives), Lives);
    wait_up(1'b0);
    round(1, int'($urandom_range(0, 30)), 1'b0, 1'b0);

    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    chk("pre_rst_up", 32'(mole_up), 1);
    chk("pre_rst_score", 32'(score), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_up", 32'(mole_up), 0);
    chk("arst_score", 32'(score), 0);
    chk("arst_lives", 32'(lives), Lives);
    chk("arst_pos", 32'(mole_pos), 0);
    chk("arst_over", 32'(game_over), 0);
    start = 1'b0;
    repeat (3) step(1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 4'd0);
      chk("idle_down", 32'(mole_up), 0);
    end
    start = 1'b1;
    wait_up(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wam_round_scheduler.md
Name: wam_round_scheduler

Overview:
- Game sequencer for the 3x3 whack-a-mole board.
- Picks a pseudo-random mole position (0-8), holds it up for a timed window and judges the keypad result as hit, wrong key or timeout.
- Tracks score and lives, and shortens the up window as the player scores.
- Sits between the keypad controller (valid_key/position) and the display/LED drivers; timing comes from an external 1 kHz tick enable.

Parameters:
- UP_TICKS, 750, initial mole-up window in ticks.
- UP_MIN, 250, floor for the up window.
- UP_STEP, 50, window reduction applied per speed-up.
- GAP_TICKS, 200, blank time between moles, in ticks.
- HITS_PER_LEVEL, 8, hits between speed-ups.
- LIVES, 3, lives at game start (1-3).
- SEED, 8'hA5, LFSR reload value (must be non-zero).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-clk-wide 1 kHz enable
- start  in  1  start/restart request, level, sampled each clk
- valid_key  in  1  keypad key-valid level; rising edge = new press
- position  in  4  keypad position 0-8, stable while valid_key high
- mole_pos  out  4  current mole position 0-8
- mole_up  out  1  mole visible
- score  out  8  hit count, saturates at 255
- lives  out  2  remaining lives
- hit_pulse  out  1  one clk on a judged hit
- miss_pulse  out  1  one clk on a wrong key or timeout
- game_over  out  1  high in OVER state

Behaviour:
- Reset (async, reset=0) forces the following values:
  - state=IDLE, mole_pos=0, mole_up=0, score=0, lives=LIVES;
  - pulses 0, game_over=0;
  - lfsr=SEED, up_window=UP_TICKS, hit_level_cnt=0, timer=0, key_prev=0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk in every state.
- Key event: key_evt = valid_key & ~key_prev, with key_prev registered every clk. position is sampled in the key_evt cycle. An event with position>8 is discarded.
- States: IDLE, SPAWN, UP, GAP, OVER.
- IDLE:
  - mole_up=0. start=1 -> SPAWN next clk.
  - Score, lives and up_window are re-initialised on this transition.
- SPAWN:
  - Candidate = lfsr[3:0].
  - Accept when candidate<=8 and candidate!=previous mole_pos. This check is skipped for the first mole after start.
  - On accept: load mole_pos, clear timer, go to UP.
  - On reject: stay in SPAWN one more clk and retry. There is no retry bound; the LFSR guarantees progress.
- UP (mole_up=1):
  - timer increments on tick.
  - key_evt with position==mole_pos -> hit:
    - score+1, saturating at 255; hit_pulse=1;
    - hit_level_cnt+1. When it reaches HITS_PER_LEVEL it wraps to 0 and up_window=max(up_window-UP_STEP, UP_MIN);
    - -> GAP.
  - key_evt with position!=mole_pos -> wrong key: miss_pulse=1, lives-1 -> GAP.
  - timer==up_window-1 with tick, and no key_evt -> timeout: miss_pulse=1, lives-1 -> GAP.
  - key_evt and timeout in the same clk: the key is judged and the timeout is ignored.
- GAP:
  - mole_up=0, timer cleared on entry, key events ignored.
  - If lives==0 (after the decrement) -> OVER immediately, with no gap wait.
  - Otherwise, after GAP_TICKS ticks -> SPAWN.
- OVER:
  - game_over=1, mole_up=0; score and lives are held.
  - start rising edge -> IDLE-style reinit and SPAWN in the same transition. start held high from the previous game does not restart; an edge is required.
- The 1-clk judge latency is fixed: mole_up falls and the pulse is asserted in the clk after key_evt.
- Mid-operation async reset returns to IDLE with all reset values, regardless of state.
- tick arriving in SPAWN, IDLE or OVER has no effect.

Test Plan:
- Reset low for 3 clks, release, start=1, no key -> SPAWN then UP with mole_pos<=8; after 750 ticks miss_pulse=1, lives 3->2, mole_up=0 for 200 ticks, then a new mole_pos different from the previous one.
- In UP with mole_pos=4, drive valid_key rising with position=4 -> next clk hit_pulse=1, score=1, lives unchanged; position=7 instead -> miss_pulse=1, lives-1.
- Key rising edge on the same clk as the timeout tick, with matching position -> hit counted, no miss, lives unchanged.
- Eight consecutive hits -> up_window 750->700; 80 more hits -> window clamps at 250 and never goes lower.
- Three misses -> game_over=1 straight after the third miss; valid_key edges ignored and score frozen; start held high gives no restart; start 0->1 -> score=0, lives=3, new mole.
- valid_key held high across a whole mole window -> exactly one judgement; position=9 edge -> ignored, mole remains up; reset asserted during UP -> mole_up=0, score=0 asynchronously.
